fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BOOT_VECTOR, default 32'h8000_0000: PC loaded at reset.
REQ-002 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port branch_request_i  input  1  redirect pulse from execute (mispredict/exception).
REQ-005 SHALL have port branch_pc_i  input  32  redirect target.
REQ-006 SHALL have port icache_rd_o  output  1  I-cache read request.
REQ-007 SHALL have port icache_pc_o  output  32  request address, {pc_q[31:3],3'b000}.
REQ-008 SHALL have port icache_accept_i  input  1  I-cache took request this cycle.
REQ-009 SHALL have port icache_valid_i  input  1  response pulse, one cycle, never before cycle after accept.
REQ-010 SHALL have port icache_inst_i  input  64  two instructions, slot0 = [31:0].
REQ-011 SHALL have port icache_error_i  input  1  bus fetch error with response.
REQ-012 SHALL have port icache_page_fault_i  input  1  page fault with response.
REQ-013 SHALL have port next_pc_f_i  input  32  predictor next PC for pc_q (sequential = {pc_q[31:3]+1,3'b000}).
REQ-014 SHALL have port next_taken_f_i  input  2  predictor taken per slot, bit0 = slot0.
REQ-015 SHALL have port fetch_out_valid_o  output  1  output buffer holds a fetch group.
REQ-016 SHALL have port fetch_out_accept_i  input  1  downstream (decode) takes group.
REQ-017 SHALL have ports fetch_out_instr_o 64, fetch_out_pc_o 32, fetch_out_fault_fetch_o 1, fetch_out_fault_page_o 1, fetch_out_pred_branch_o 2, all outputs, registered with group.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH (no request outstanding), WAIT (one outstanding, keep response), DROP (one outstanding, discard response).
REQ-019 SHALL transition IDLE->FETCH unconditionally one cycle after reset release.
REQ-020 SHALL drive icache_rd_o = (state==FETCH) & ~branch_request_i & (~fetch_out_valid_o | fetch_out_accept_i); combinational, 0 in IDLE.
REQ-021 SHALL hold icache_pc_o stable while icache_rd_o high and not accepted, except on redirect.
REQ-022 SHALL on icache_rd_o & icache_accept_i: go FETCH->WAIT, load pc_q <= next_pc_f_i, capture req_pc_q <= pc_q and pred_q <= next_taken_f_i.
REQ-023 SHALL allow at most one outstanding request; no request in WAIT or DROP.
REQ-024 SHALL on icache_valid_i in WAIT (no redirect): load output buffer {instr, pc=req_pc_q, faults, pred=pred_q}, set fetch_out_valid_o, go FETCH; new request allowed from next cycle.
REQ-025 SHALL on icache_valid_i in DROP: discard data, leave buffer unchanged, go FETCH.
REQ-026 SHALL clear fetch_out_valid_o on fetch_out_accept_i & fetch_out_valid_o unless reloaded same cycle.
REQ-027 SHALL on branch_request_i (priority over all else): pc_q <= branch_pc_i, clear fetch_out_valid_o, discard any same-cycle icache_valid_i; WAIT->DROP; DROP stays DROP; FETCH/IDLE->FETCH.
REQ-028 SHALL treat icache_valid_i in FETCH or IDLE as spurious and ignore it.
REQ-029 SHALL pass faults unmodified; instr passes as received (zeroing done downstream).
REQ-030 SHALL wrap pc arithmetic modulo 2^32 (no saturation).

Reset
REQ-031 SHALL on rstn_i low: state IDLE, pc_q = BOOT_VECTOR, fetch_out_valid_o = 0, icache_rd_o = 0, all other outputs 0, req_pc_q/pred_q = 0.
REQ-032 SHALL abandon any outstanding request on reset; responses in first cycles after release ignored (REQ-028).

Verification
REQ-033 Reset release, accept in first FETCH cycle, next_pc_f_i=0x8000_0008, response instr=64'h0000_0013_0000_0093 two cycles later -> icache_pc_o=0x8000_0000, then fetch_out_valid_o=1, pc=0x8000_0000, pred=0.
REQ-034 Downstream stalls with group held -> icache_rd_o=0 until fetch_out_accept_i=1; then rd_o=1 same cycle, PC 0x8000_0008.
REQ-035 Redirect to 0x8000_0100 while in WAIT, response arrives next cycle -> response discarded, no valid output, next request pc=0x8000_0100.
REQ-036 Redirect same cycle as icache_valid_i and fetch_out_valid_o=1 -> buffer cleared, data dropped, state FETCH, request to branch_pc_i next cycle.
REQ-037 Response with icache_page_fault_i=1, next_taken_f_i=2'b01 -> fetch_out_fault_page_o=1, fault_fetch_o=0, pred_branch_o=2'b01.
REQ-038 Assert rstn_i low in WAIT -> immediately outputs 0, pc_q=BOOT_VECTOR; late response after release produces no output.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding I-cache request, a single-entry
// output buffer toward decode, and redirect handling that can drop an in-flight response.
module fetch_unit #(
  parameter logic [31:0] BOOT_VECTOR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,

  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,

  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,

  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,

  output logic        fetch_out_valid_o,
  input  logic        fetch_out_accept_i,
  output logic [63:0] fetch_out_instr_o,
  output logic [31:0] fetch_out_pc_o,
  output logic        fetch_out_fault_fetch_o,
  output logic        fetch_out_fault_page_o,
  output logic [1:0]  fetch_out_pred_branch_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  pred_q, pred_d;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_fault_fetch_q, out_fault_fetch_d;
  logic        out_fault_page_q, out_fault_page_d;
  logic [1:0]  out_pred_q, out_pred_d;

  logic        out_free;
  logic        fetch_fire;

  // The buffer may be refilled in the same cycle decode drains it.
  assign out_free    = ~out_valid_q | fetch_out_accept_i;
  assign icache_rd_o = (state_q == ST_FETCH) & ~branch_request_i & out_free;
  assign icache_pc_o = {pc_q[31:3], 3'b000};
  assign fetch_fire  = icache_rd_o & icache_accept_i;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d           = state_q;
    pc_d              = pc_q;
    req_pc_d          = req_pc_q;
    pred_d            = pred_q;
    out_valid_d       = out_valid_q;
    out_instr_d       = out_instr_q;
    out_pc_d          = out_pc_q;
    out_fault_fetch_d = out_fault_fetch_q;
    out_fault_page_d  = out_fault_page_q;
    out_pred_d        = out_pred_q;

    if (out_valid_q && fetch_out_accept_i) begin
      out_valid_d = 1'b0;
    end

    if (branch_request_i) begin
      pc_d        = branch_pc_i;
      out_valid_d = 1'b0;
      // A response arriving with the redirect retires the outstanding request,
      // so only a still-pending request needs the DROP state.
      if ((state_q == ST_WAIT || state_q == ST_DROP) && !icache_valid_i) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (fetch_fire) begin
            state_d  = ST_WAIT;
            pc_d     = next_pc_f_i;
            req_pc_d = pc_q;
            pred_d   = next_taken_f_i;
          end
        end
        ST_WAIT: begin
          if (icache_valid_i) begin
            state_d           = ST_FETCH;
            out_valid_d       = 1'b1;
            out_instr_d       = icache_inst_i;
            out_pc_d          = req_pc_q;
            out_fault_fetch_d = icache_error_i;
            out_fault_page_d  = icache_page_fault_i;
            out_pred_d        = pred_q;
          end
        end
        ST_DROP: begin
          if (icache_valid_i) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q           <= ST_IDLE;
      pc_q              <= BOOT_VECTOR;
      req_pc_q          <= '0;
      pred_q            <= '0;
      out_valid_q       <= 1'b0;
      out_instr_q       <= '0;
      out_pc_q          <= '0;
      out_fault_fetch_q <= 1'b0;
      out_fault_page_q  <= 1'b0;
      out_pred_q        <= '0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      req_pc_q          <= req_pc_d;
      pred_q            <= pred_d;
      out_valid_q       <= out_valid_d;
      out_instr_q       <= out_instr_d;
      out_pc_q          <= out_pc_d;
      out_fault_fetch_q <= out_fault_fetch_d;
      out_fault_page_q  <= out_fault_page_d;
      out_pred_q        <= out_pred_d;
    end
  end

  assign fetch_out_valid_o       = out_valid_q;
  assign fetch_out_instr_o       = out_instr_q;
  assign fetch_out_pc_o          = out_pc_q;
  assign fetch_out_fault_fetch_o = out_fault_fetch_q;
  assign fetch_out_fault_page_o  = out_fault_page_q;
  assign fetch_out_pred_branch_o = out_pred_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table for the request side, plus a
// scoreboard of expected fetch groups consumed when decode accepts them.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic [63:0] icache_inst_i;
  logic        icache_error_i;
  logic        icache_page_fault_i;
  logic [31:0] next_pc_f_i;
  logic [1:0]  next_taken_f_i;
  logic        fetch_out_valid_o;
  logic        fetch_out_accept_i;
  logic [63:0] fetch_out_instr_o;
  logic [31:0] fetch_out_pc_o;
  logic        fetch_out_fault_fetch_o;
  logic        fetch_out_fault_page_o;
  logic [1:0]  fetch_out_pred_branch_o;

  fetch_unit #(.BOOT_VECTOR(32'h8000_0000)) dut (
    .clk_i                   (clk_i),
    .rstn_i                  (rstn_i),
    .branch_request_i        (branch_request_i),
    .branch_pc_i             (branch_pc_i),
    .icache_rd_o             (icache_rd_o),
    .icache_pc_o             (icache_pc_o),
    .icache_accept_i         (icache_accept_i),
    .icache_valid_i          (icache_valid_i),
    .icache_inst_i           (icache_inst_i),
    .icache_error_i          (icache_error_i),
    .icache_page_fault_i     (icache_page_fault_i),
    .next_pc_f_i             (next_pc_f_i),
    .next_taken_f_i          (next_taken_f_i),
    .fetch_out_valid_o       (fetch_out_valid_o),
    .fetch_out_accept_i      (fetch_out_accept_i),
    .fetch_out_instr_o       (fetch_out_instr_o),
    .fetch_out_pc_o          (fetch_out_pc_o),
    .fetch_out_fault_fetch_o (fetch_out_fault_fetch_o),
    .fetch_out_fault_page_o  (fetch_out_fault_page_o),
    .fetch_out_pred_branch_o (fetch_out_pred_branch_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        br;
    logic [31:0] br_pc;
    logic        acc;
    logic [31:0] npc;
    logic [1:0]  ntk;
    logic        vld;
    logic [63:0] inst;
    logic        err;
    logic        pf;
    logic        oacc;
    logic        e_rd;
    logic [31:0] e_pc;
    logic        e_ov;
    logic        push;
    logic [31:0] push_pc;
    logic [1:0]  push_pred;
  } vec_t;

  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] pc;
    logic        err;
    logic        pf;
    logic [1:0]  pred;
  } grp_t;

  localparam int NVEC = 28;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] I0   = 64'h0000_0013_0000_0093;
  localparam logic [63:0] I1   = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] I2   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] I3   = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] I4   = 64'h5555_6666_7777_8888;

  vec_t vecs [NVEC];
  grp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic br, input logic [31:0] br_pc, input logic acc, input logic [31:0] npc,
    input logic [1:0] ntk, input logic vld, input logic [63:0] inst, input logic err,
    input logic pf, input logic oacc, input logic e_rd, input logic [31:0] e_pc,
    input logic e_ov, input logic push, input logic [31:0] push_pc, input logic [1:0] push_pred);
    vec_t v;
    v.br = br; v.br_pc = br_pc; v.acc = acc; v.npc = npc; v.ntk = ntk;
    v.vld = vld; v.inst = inst; v.err = err; v.pf = pf; v.oacc = oacc;
    v.e_rd = e_rd; v.e_pc = e_pc; v.e_ov = e_ov;
    v.push = push; v.push_pc = push_pc; v.push_pred = push_pred;
    return v;
  endfunction

  task automatic drive_idle();
    branch_request_i    = 1'b0;
    branch_pc_i         = '0;
    icache_accept_i     = 1'b0;
    icache_valid_i      = 1'b0;
    icache_inst_i       = '0;
    icache_error_i      = 1'b0;
    icache_page_fault_i = 1'b0;
    next_pc_f_i         = '0;
    next_taken_f_i      = '0;
    fetch_out_accept_i  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd"},    64'(icache_rd_o), 64'd0);
    check({tag, "_ov"},    64'(fetch_out_valid_o), 64'd0);
    check({tag, "_instr"}, fetch_out_instr_o, 64'd0);
    check({tag, "_opc"},   64'(fetch_out_pc_o), 64'd0);
    check({tag, "_ff"},    64'(fetch_out_fault_fetch_o), 64'd0);
    check({tag, "_fp"},    64'(fetch_out_fault_page_o), 64'd0);
    check({tag, "_pred"},  64'(fetch_out_pred_branch_o), 64'd0);
  endtask

  initial begin
    //             br bpc           acc npc           ntk    vld inst err pf oacc rd pc            ov push ppc           ppred
    vecs[0]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, JUNK, 0, 0, 0,  0, 32'h8000_0000, 0, 0, 32'h0,        2'b00);
    vecs[1]  = mk(0, 32'h0,        1, 32'h8000_0008, 2'b00, 0, 64'h0, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 32'h0,        2'b00);
    vecs[2]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 0, 0, 32'h8000_0008, 0, 0, 32'h0,        2'b00);
    vecs[3]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, I0,   0, 0, 0,  0, 32'h8000_0008, 0, 1, 32'h8000_0000, 2'b00);
    vecs[4]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 0, 0, 32'h8000_0008, 1, 0, 32'h0,        2'b00);
    vecs[5]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 0, 0, 32'h8000_0008, 1, 0, 32'h0,        2'b00);
    vecs[6]  = mk(0, 32'h0,        1, 32'h8000_0010, 2'b01, 0, 64'h0, 0, 0, 1, 1, 32'h8000_0008, 1, 0, 32'h0,        2'b00);
    vecs[7]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, I1,   0, 1, 0,  0, 32'h8000_0010, 0, 1, 32'h8000_0008, 2'b01);
    vecs[8]  = mk(0, 32'h0,        0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 1, 1, 32'h8000_0010, 1, 0, 32'h0,        2'b00);
    vecs[9]  = mk(0, 32'h0,        1, 32'h8000_0018, 2'b00, 0, 64'h0, 0, 0, 0, 1, 32'h8000_0010, 0, 0, 32'h0,        2'b00);
    vecs[10] = mk(1, 32'h8000_0100, 0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 0, 0, 32'h8000_0018, 0, 0, 32'h0,        2'b00);
    vecs[11] = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, JUNK, 0, 0, 0,  0, 32'h8000_0100, 0, 0, 32'h0,        2'b00);
    vecs[12] = mk(0, 32'h0,        1, 32'h8000_0108, 2'b00, 0, 64'h0, 0, 0, 0, 1, 32'h8000_0100, 0, 0, 32'h0,        2'b00);
    vecs[13] = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, I2,   1, 0, 0,  0, 32'h8000_0108, 0, 1, 32'h8000_0100, 2'b00);
    vecs[14] = mk(0, 32'h0,        1, 32'h8000_0110, 2'b10, 0, 64'h0, 0, 0, 1, 1, 32'h8000_0108, 1, 0, 32'h0,        2'b00);
    vecs[15] = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, I3,   0, 0, 0,  0, 32'h8000_0110, 0, 1, 32'h8000_0108, 2'b10);
    vecs[16] = mk(1, 32'h8000_0200, 0, 32'h0,        2'b00, 1, JUNK, 0, 0, 0,  0, 32'h8000_0110, 1, 0, 32'h0,        2'b00);
    vecs[17] = mk(0, 32'h0,        1, 32'h8000_0208, 2'b00, 0, 64'h0, 0, 0, 0, 1, 32'h8000_0200, 0, 0, 32'h0,        2'b00);
    vecs[18] = mk(1, 32'hFFFF_FFFC, 0, 32'h0,        2'b00, 1, JUNK, 0, 0, 0,  0, 32'h8000_0208, 0, 0, 32'h0,        2'b00);
    vecs[19] = mk(0, 32'h0,        1, 32'h0000_0000, 2'b11, 0, 64'h0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,        2'b00);
    vecs[20] = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, I4,   0, 0, 0,  0, 32'h0000_0000, 0, 1, 32'hFFFF_FFFC, 2'b11);
    vecs[21] = mk(0, 32'h0,        0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 1, 1, 32'h0000_0000, 1, 0, 32'h0,        2'b00);
    vecs[22] = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, JUNK, 0, 0, 0,  1, 32'h0000_0000, 0, 0, 32'h0,        2'b00);
    vecs[23] = mk(0, 32'h0,        1, 32'h0000_0008, 2'b00, 0, 64'h0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 32'h0,        2'b00);
    vecs[24] = mk(1, 32'h8000_0300, 0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 0, 0, 32'h0000_0008, 0, 0, 32'h0,        2'b00);
    vecs[25] = mk(1, 32'h8000_0400, 0, 32'h0,        2'b00, 0, 64'h0, 0, 0, 0, 0, 32'h8000_0300, 0, 0, 32'h0,        2'b00);
    vecs[26] = mk(0, 32'h0,        0, 32'h0,        2'b00, 1, JUNK, 0, 0, 0,  0, 32'h8000_0400, 0, 0, 32'h0,        2'b00);
    vecs[27] = mk(0, 32'h0,        1, 32'h8000_0408, 2'b00, 0, 64'h0, 0, 0, 0, 1, 32'h8000_0400, 0, 0, 32'h0,        2'b00);

    rstn_i = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk_i);
    #1;
    check_outputs_zero("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      logic popped;
      grp_t g;
      branch_request_i    = vecs[i].br;
      branch_pc_i         = vecs[i].br_pc;
      icache_accept_i     = vecs[i].acc;
      next_pc_f_i         = vecs[i].npc;
      next_taken_f_i      = vecs[i].ntk;
      icache_valid_i      = vecs[i].vld;
      icache_inst_i       = vecs[i].inst;
      icache_error_i      = vecs[i].err;
      icache_page_fault_i = vecs[i].pf;
      fetch_out_accept_i  = vecs[i].oacc;
      #1;
      check($sformatf("row%0d_rd", i), 64'(icache_rd_o), 64'(vecs[i].e_rd));
      check($sformatf("row%0d_pc", i), 64'(icache_pc_o), 64'(vecs[i].e_pc));
      check($sformatf("row%0d_ov", i), 64'(fetch_out_valid_o), 64'(vecs[i].e_ov));

      popped = 1'b0;
      if (fetch_out_valid_o && vecs[i].oacc) begin
        popped = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL row%0d_group: got unexpected group pc %h expected none", i, fetch_out_pc_o);
        end else begin
          g = sb.pop_front();
          check($sformatf("row%0d_g_instr", i), fetch_out_instr_o, g.instr);
          check($sformatf("row%0d_g_pc", i),    64'(fetch_out_pc_o), 64'(g.pc));
          check($sformatf("row%0d_g_ff", i),    64'(fetch_out_fault_fetch_o), 64'(g.err));
          check($sformatf("row%0d_g_fp", i),    64'(fetch_out_fault_page_o), 64'(g.pf));
          check($sformatf("row%0d_g_pred", i),  64'(fetch_out_pred_branch_o), 64'(g.pred));
        end
      end
      // A redirect kills whatever group decode has not taken.
      if (vecs[i].br && !popped) sb.delete();
      if (vecs[i].push) begin
        g.instr = vecs[i].inst;
        g.pc    = vecs[i].push_pc;
        g.err   = vecs[i].err;
        g.pf    = vecs[i].pf;
        g.pred  = vecs[i].push_pred;
        sb.push_back(g);
      end
      @(negedge clk_i);
    end

    // Reset while a request is outstanding, then a late response after release.
    drive_idle();
    #1;
    check("wait_rd", 64'(icache_rd_o), 64'd0);
    check("wait_pc", 64'(icache_pc_o), 64'h8000_0408);
    rstn_i = 1'b0;
    #1;
    check_outputs_zero("midreset");
    check("midreset_pc", 64'(icache_pc_o), 64'h8000_0000);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check("rel_idle_rd", 64'(icache_rd_o), 64'd0);
    @(negedge clk_i);
    icache_valid_i = 1'b1;
    icache_inst_i  = JUNK;
    #1;
    check("rel_fetch_rd", 64'(icache_rd_o), 64'd1);
    check("rel_fetch_pc", 64'(icache_pc_o), 64'h8000_0000);
    @(negedge clk_i);
    drive_idle();
    #1;
    check("late_resp_ov", 64'(fetch_out_valid_o), 64'd0);
    check("late_resp_rd", 64'(icache_rd_o), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
